// File: rtl/loader_pkg.sv
// Shared types for the instruction-memory program loader.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    DONE  = 3'd3,
    ERROR = 3'd4
  } state_t;

  localparam int unsigned LANES = 4;

  typedef struct packed {
    logic ready;
    logic busy;
    logic core_reset;
    logic done;
    logic error;
  } status_t;

  // Status outputs are a pure decode of the state they will accompany.
  function automatic status_t decode_status(input state_t s);
    status_t f;
    f.ready      = (s == LOAD) || (s == CHECK);
    f.busy       = (s == LOAD) || (s == CHECK);
    f.core_reset = (s != DONE);
    f.done       = (s == DONE);
    f.error      = (s == ERROR);
    return f;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs accepted bytes little-endian into 32-bit words with a one-cycle word strobe.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        take,
  input  logic [7:0]  data,
  output logic        last_lane,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  lane;
  logic [23:0] partial;

  assign last_lane = take && (lane == 2'(LANES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      lane       <= '0;
      partial    <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        lane    <= '0;
        partial <= '0;
      end else if (take) begin
        lane <= lane + 2'd1;
        // Earlier bytes shift down so the first one lands in bits [7:0].
        if (last_lane) begin
          word       <= {data, partial};
          word_valid <= 1'b1;
        end else begin
          partial <= {data, partial[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream loader for instruction memory; releases core reset only on a verified image.
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   wordCount,
  input  logic [7:0]            byteIn,
  input  logic                  byteValid,
  output logic                  byteReady,
  output logic                  imemWriteEn,
  output logic [31:0]           imemWriteAddr,
  output logic [31:0]           imemWriteData,
  output logic                  coreReset,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state, next_state;
  status_t             status;
  logic [ADDR_WIDTH:0] word_total, word_idx;
  logic [7:0]          checksum, sum_next;
  logic                accept, start_load, last_lane, word_valid;

  assign accept     = byteValid && status.ready;
  assign start_load = start && (state == IDLE || state == DONE || state == ERROR);
  assign sum_next   = checksum + byteIn;

  byte_packer packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_load),
    .take       (accept && (state == LOAD)),
    .data       (byteIn),
    .last_lane  (last_lane),
    .word_valid (word_valid),
    .word       (imemWriteData)
  );

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE, DONE, ERROR:
        if (start) begin
          if (wordCount == '0)            next_state = CHECK;
          else if (wordCount > CAPACITY)  next_state = ERROR;
          else                            next_state = LOAD;
        end
      // word_idx already counts every earlier word: its strobe precedes this word's 4th byte.
      LOAD:
        if (last_lane && (word_idx == word_total - 1'b1)) next_state = CHECK;
      CHECK:
        if (accept) next_state = (sum_next == 8'h00) ? DONE : ERROR;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      status     <= decode_status(IDLE);
      word_total <= '0;
      word_idx   <= '0;
      checksum   <= '0;
    end else begin
      state  <= next_state;
      status <= decode_status(next_state);
      if (start_load) begin
        word_total <= wordCount;
        word_idx   <= '0;
        checksum   <= '0;
      end else begin
        if (word_valid) word_idx <= word_idx + 1'b1;
        if (accept)     checksum <= sum_next;
      end
    end
  end

  assign imemWriteEn   = word_valid;
  assign imemWriteAddr = BASE_ADDR + (32'(word_idx) << 2);
  assign byteReady     = status.ready;
  assign busy          = status.busy;
  assign coreReset     = status.core_reset;
  assign done          = status.done;
  assign error         = status.error;

endmodule
